// File: rtl/pci_addr_decoder.sv
// rtl/pci_addr_decoder.sv - PCI target address-phase decoder feeding the DEVSEL# stage
// Latches the address phase, matches three BAR windows and tracks burst data phases.
module pci_addr_decoder #(
  parameter logic [31:0] BAR0_BASE     = 32'h1000_0000,
  parameter logic [31:0] BAR1_BASE     = 32'h2000_0000,
  parameter logic [31:0] BAR2_BASE     = 32'h3000_0000,
  parameter int          BAR_SIZE_LOG2 = 6
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        frame,
  input  logic        irdy,
  input  logic        trdy,
  input  logic [31:0] ad,
  input  logic [3:0]  cbe,
  output logic [1:0]  decoderInput,
  output logic        hit,
  output logic [3:0]  cmd,
  output logic        is_read,
  output logic        is_write,
  output logic [31:0] cur_addr,
  output logic        bar_end,
  output logic        last_phase
);

  localparam int L = BAR_SIZE_LOG2;

  typedef enum logic [1:0] {IDLE, DATA, TURN} state_t;

  state_t      state, stateNext;
  logic        frameQ;
  logic [1:0]  decNext;
  logic        hitNext, rdNext, wrNext, lastNext, barEndNext;
  logic [3:0]  cmdNext;
  logic [31:0] addrNext, adWord;
  logic        addrPhase, completion;
  logic        bar0Match, bar1Match, bar2Match, anyMatch, cmdOk, claim;
  logic [1:0]  barIdx;

  assign adWord     = ad & 32'hFFFF_FFFC;
  assign addrPhase  = !frame && frameQ;
  assign completion = !irdy && !trdy;

  assign bar0Match = adWord[31:L] == BAR0_BASE[31:L];
  assign bar1Match = adWord[31:L] == BAR1_BASE[31:L];
  assign bar2Match = adWord[31:L] == BAR2_BASE[31:L];
  assign anyMatch  = bar0Match || bar1Match || bar2Match;
  assign barIdx    = bar0Match ? 2'd0 : (bar1Match ? 2'd1 : 2'd2);
  assign cmdOk     = cbe inside {4'b0110, 4'b0111, 4'b1100, 4'b1110};
  assign claim     = anyMatch && cmdOk;

  always_comb begin
    stateNext = state;
    decNext   = decoderInput;
    hitNext   = hit;
    cmdNext   = cmd;
    rdNext    = is_read;
    wrNext    = is_write;
    addrNext  = cur_addr;
    lastNext  = 1'b0;
    case (state)
      IDLE: begin
        if (addrPhase) begin
          stateNext = DATA;
          cmdNext   = cbe;
          addrNext  = adWord;
          hitNext   = claim;
          decNext   = claim ? barIdx : 2'd3;
          rdNext    = claim && (cbe inside {4'b0110, 4'b1100, 4'b1110});
          wrNext    = claim && (cbe == 4'b0111);
        end
      end
      DATA: begin
        if (hit && completion) begin
          // Burst stops at the last dword of the window rather than wrapping out of it
          if (!bar_end) addrNext = cur_addr + 32'd4;
          if (frame) begin
            lastNext  = 1'b1;
            stateNext = TURN;
          end
        end else if (frame && irdy) begin
          stateNext = TURN;
        end
      end
      TURN: begin
        decNext   = 2'd3;
        hitNext   = 1'b0;
        rdNext    = 1'b0;
        wrNext    = 1'b0;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    barEndNext = hitNext && (&addrNext[L-1:2]);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state        <= IDLE;
      frameQ       <= 1'b1;
      decoderInput <= 2'd3;
      hit          <= 1'b0;
      cmd          <= 4'd0;
      is_read      <= 1'b0;
      is_write     <= 1'b0;
      cur_addr     <= 32'd0;
      bar_end      <= 1'b0;
      last_phase   <= 1'b0;
    end else begin
      state        <= stateNext;
      frameQ       <= frame;
      decoderInput <= decNext;
      hit          <= hitNext;
      cmd          <= cmdNext;
      is_read      <= rdNext;
      is_write     <= wrNext;
      cur_addr     <= addrNext;
      bar_end      <= barEndNext;
      last_phase   <= lastNext;
    end
  end

endmodule

// File: tb/tb_pci_addr_decoder.sv
// tb/tb_pci_addr_decoder.sv - scoreboard bench for pci_addr_decoder
// Driver pushes reference-model outputs per cycle; monitor pops and compares after each posedge.
module tb_pci_addr_decoder;

  localparam int          LOG2 = 6;
  localparam logic [31:0] WSZ  = 32'd1 << LOG2;

  logic        clk = 1'b0;
  logic        RST, frame, irdy, trdy;
  logic [31:0] ad;
  logic [3:0]  cbe;
  logic [1:0]  decoderInput;
  logic        hit, is_read, is_write, bar_end, last_phase;
  logic [3:0]  cmd;
  logic [31:0] cur_addr;

  typedef struct packed {
    logic [1:0]  dec;
    logic        hit;
    logic [3:0]  cmd;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic        be;
    logic        lp;
  } outs_t;

  outs_t expQ[$];
  int    nTests = 0;
  int    nFail  = 0;

  logic [31:0] bases[3] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000};

  // Reference model: phase 0 = idle, 1 = in transaction, 2 = turnaround
  int    mPhase;
  bit    mFrameQ;
  outs_t m;

  always #5 clk = ~clk;

  pci_addr_decoder dut (
    .clk(clk), .RST(RST), .frame(frame), .irdy(irdy), .trdy(trdy), .ad(ad), .cbe(cbe),
    .decoderInput(decoderInput), .hit(hit), .cmd(cmd), .is_read(is_read),
    .is_write(is_write), .cur_addr(cur_addr), .bar_end(bar_end), .last_phase(last_phase)
  );

  function automatic bit isLastDword(input logic [31:0] a);
    return (a % WSZ) == (WSZ - 32'd4);
  endfunction

  task automatic modelStep();
    int idx;
    if (RST) begin
      mPhase = 0; mFrameQ = 1'b1;
      m = '{dec: 2'd3, default: '0};
      return;
    end
    m.lp = 1'b0;
    if (mPhase == 0) begin
      if (!frame && mFrameQ) begin
        idx = -1;
        for (int i = 2; i >= 0; i--)
          if ((ad >> LOG2) == (bases[i] >> LOG2)) idx = i;
        m.cmd  = cbe;
        m.addr = ad - (ad % 32'd4);
        m.hit  = (idx >= 0) && (cbe == 4'h6 || cbe == 4'h7 || cbe == 4'hC || cbe == 4'hE);
        m.dec  = m.hit ? 2'(idx) : 2'd3;
        m.rd   = m.hit && (cbe == 4'h6 || cbe == 4'hC || cbe == 4'hE);
        m.wr   = m.hit && (cbe == 4'h7);
        m.be   = m.hit && isLastDword(m.addr);
        mPhase = 1;
      end
    end else if (mPhase == 1) begin
      if (m.hit && !irdy && !trdy) begin
        if (!isLastDword(m.addr)) m.addr = m.addr + 32'd4;
        m.be = isLastDword(m.addr);
        if (frame) begin
          m.lp = 1'b1; mPhase = 2;
        end
      end else if (frame && irdy) begin
        mPhase = 2;
      end
    end else begin
      m.dec = 2'd3; m.hit = 1'b0; m.rd = 1'b0; m.wr = 1'b0; m.be = 1'b0;
      mPhase = 0;
    end
    mFrameQ = frame;
  endtask

  task automatic drive(input bit r, input bit f, input bit i, input bit t,
                       input logic [31:0] a, input logic [3:0] c);
    RST = r; frame = f; irdy = i; trdy = t; ad = a; cbe = c;
    modelStep();
    expQ.push_back(m);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 1, 1, 1, $urandom, 4'($urandom));
  endtask

  task automatic randTxn();
    int          sel, nph, done;
    logic [31:0] a;
    logic [3:0]  c;
    bit          i, t, f;
    logic [3:0]  legal[4] = '{4'h6, 4'h7, 4'hC, 4'hE};
    sel = $urandom_range(0, 3);
    a = (sel < 3) ? bases[sel] + 32'($urandom_range(0, 15) * 4) : $urandom;
    c = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 3)] : 4'($urandom);
    nph = $urandom_range(1, 8);
    drive(0, 0, 1, 1, a | 32'($urandom_range(0, 3)), c);
    done = 0;
    for (int k = 0; k < 25 && done < nph; k++) begin
      i = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 3) == 0);
      f = (done == nph - 1) && !i && !t;
      drive(($urandom_range(0, 99) == 0), f, i, t, $urandom, 4'($urandom));
      if (!i && !t) done++;
    end
    idle($urandom_range(2, 3));
  endtask

  initial begin : monitor
    outs_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        g = '{decoderInput, hit, cmd, is_read, is_write, cur_addr, bar_end, last_phase};
        nTests++;
        if (g !== e) begin
          nFail++;
          $display("FAIL outputs t=%0t: got dec=%0d hit=%0b cmd=%h rd=%0b wr=%0b addr=%h be=%0b lp=%0b required dec=%0d hit=%0b cmd=%h rd=%0b wr=%0b addr=%h be=%0b lp=%0b",
                   $time, g.dec, g.hit, g.cmd, g.rd, g.wr, g.addr, g.be, g.lp,
                   e.dec, e.hit, e.cmd, e.rd, e.wr, e.addr, e.be, e.lp);
        end
      end
    end
  end

  initial begin : stimulus
    RST = 1; frame = 1; irdy = 1; trdy = 1; ad = '0; cbe = '0;
    mPhase = 0; mFrameQ = 1'b1; m = '{dec: 2'd3, default: '0};
    @(negedge clk);
    drive(1, 1, 1, 1, 0, 0);
    drive(1, 1, 1, 1, 0, 0);
    // Write burst to BAR1, three completions, frame released on the last
    drive(0, 0, 1, 1, 32'h2000_0010, 4'b0111);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    idle(3);
    // Unclaimed address: stays in data until frame and irdy both high
    drive(0, 0, 1, 1, 32'h5000_0000, 4'b0110);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    idle(3);
    // BAR0 match but I/O read command
    drive(0, 0, 1, 1, 32'h1000_0000, 4'b0010);
    idle(3);
    // Burst hitting the window end, further completions hold
    drive(0, 0, 1, 1, 32'h1000_0038, 4'b0110);
    for (int k = 0; k < 5; k++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    idle(3);
    // Reset mid-burst
    drive(0, 0, 1, 1, 32'h2000_0010, 4'b0111);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    idle(2);
    // Reset coincident with an address phase
    drive(1, 0, 1, 1, 32'h1000_0000, 4'b0110);
    idle(2);
    for (int n = 0; n < 80; n++) randTxn();
    repeat (4) @(posedge clk);
    #2;
    nTests++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("FAIL drain: got %0d pending, required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
